// File: rtl/dmem_pkg.sv
// Shared types and widths for the riscv32s data-memory path.
package dmem_pkg;

  localparam int unsigned ADDR_W_DEF = 10;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned CNT_W      = 8;

  typedef enum logic [0:0] {OWN_CORE, OWN_DMA} owner_t;

endpackage

// File: rtl/arb_counter.sv
// Saturating up-counter with synchronous clear (clear has priority over increment).
module arb_counter #(
  parameter int unsigned W   = 8,
  parameter int unsigned MAX = 255
) (
  input  logic         clock,
  input  logic         nreset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != W'(MAX))) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data RAM between the core load/store port and a
// DMA port; DMA gets bounded bursts and a starvation guarantee.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned BURST_MAX    = 8,
  parameter int unsigned STARVE_LIMIT = 16
) (
  input  logic              clock,
  input  logic              nreset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  owner_t           state, state_next;
  logic [CNT_W-1:0] beat_cnt, starve_cnt;
  logic             dma_beat, burst_done, starved;

  assign dma_beat   = (state == OWN_DMA) && dma_req;
  assign burst_done = dma_beat && (beat_cnt == CNT_W'(BURST_MAX - 1));
  assign starved    = dma_req && core_req && (starve_cnt == CNT_W'(STARVE_LIMIT - 1));

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) state <= OWN_CORE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      OWN_CORE: if (dma_req && (!core_req || starved)) state_next = OWN_DMA;
      OWN_DMA:  if (!dma_req || burst_done)            state_next = OWN_CORE;
      default:  state_next = OWN_CORE;
    endcase
  end

  // With no DMA beat the core owns the RAM, even in DMA state (no stall then).
  always_comb begin
    dma_gnt    = dma_beat;
    core_stall = dma_beat && core_req;
    if (dma_beat) begin
      ram_we    = dma_we;
      ram_addr  = dma_addr;
      ram_wdata = dma_wdata;
    end else begin
      ram_we    = core_req && core_we;
      ram_addr  = core_req ? core_addr  : '0;
      ram_wdata = core_req ? core_wdata : '0;
    end
  end

  assign core_rdata = ram_rdata;

  arb_counter #(.W(CNT_W), .MAX(BURST_MAX)) u_beat_cnt (
    .clock  (clock),
    .nreset (nreset),
    .clr    (state_next == OWN_CORE),
    .inc    (dma_beat),
    .count  (beat_cnt)
  );

  arb_counter #(.W(CNT_W), .MAX(STARVE_LIMIT - 1)) u_starve_cnt (
    .clock  (clock),
    .nreset (nreset),
    .clr    (!dma_req || (state == OWN_DMA) || (state_next == OWN_DMA)),
    .inc    ((state == OWN_CORE) && dma_req && core_req),
    .count  (starve_cnt)
  );

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      dma_rvalid <= 1'b0;
      dma_rdata  <= '0;
    end else begin
      dma_rvalid <= dma_beat && !dma_we;
      if (dma_beat && !dma_we) dma_rdata <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and randomized checks of dmem_arbiter against a cycle-level ownership model.
module tb_dmem_arbiter;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;
  localparam int unsigned BURST_MAX = 8;
  localparam int unsigned STARVE_LIMIT = 16;

  logic          clock = 1'b0;
  logic          nreset;
  logic          core_req, core_we, dma_req, dma_we;
  logic [AW-1:0] core_addr, dma_addr;
  logic [DW-1:0] core_wdata, dma_wdata;
  logic [DW-1:0] core_rdata, dma_rdata, ram_wdata, ram_rdata;
  logic          core_stall, dma_gnt, dma_rvalid, ram_we;
  logic [AW-1:0] ram_addr;

  logic [DW-1:0] mem [0:1023];
  logic [DW-1:0] exp_mem [0:1023];

  int errors = 0;
  int checks = 0;

  bit            m_dma;
  int            m_beats, m_waited;
  bit            m_rv;
  logic [DW-1:0] m_rd;
  bit            last_gnt, last_stall;

  always #5 clock = ~clock;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_MAX(BURST_MAX), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clock(clock), .nreset(nreset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_rdata(core_rdata), .core_stall(core_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  assign ram_rdata = mem[ram_addr];

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    forever begin
      @(posedge clock);
      if (ram_we) mem[ram_addr] <= ram_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_dma = 0; m_beats = 0; m_waited = 0; m_rv = 0; m_rd = '0;
  endtask

  // Evaluate one cycle: compare DUT against the ownership rules, then advance the model.
  task automatic step_model();
    bit            dserv, stall, core_ok;
    logic          we_e;
    logic [AW-1:0] a_e;
    logic [DW-1:0] d_e;
    dserv   = m_dma && dma_req;
    stall   = dserv && core_req;
    core_ok = core_req && !stall;
    we_e    = dserv ? dma_we : (core_req && core_we);
    a_e     = dserv ? dma_addr : core_addr;
    d_e     = dserv ? dma_wdata : core_wdata;
    chk("dma_gnt", {31'b0, dma_gnt}, {31'b0, dserv});
    chk("core_stall", {31'b0, core_stall}, {31'b0, stall});
    chk("ram_we", {31'b0, ram_we}, {31'b0, we_e});
    if (dserv || core_req) chk("ram_addr", {22'b0, ram_addr}, {22'b0, a_e});
    if (we_e) chk("ram_wdata", ram_wdata, d_e);
    if (core_ok && !core_we) chk("core_rdata", core_rdata, exp_mem[core_addr]);
    chk("dma_rvalid", {31'b0, dma_rvalid}, {31'b0, m_rv});
    chk("dma_rdata", dma_rdata, m_rd);

    m_rv = dserv && !dma_we;
    if (m_rv) m_rd = exp_mem[dma_addr];
    if (we_e) exp_mem[a_e] = d_e;
    last_gnt = dserv;
    last_stall = stall;
    if (m_dma) begin
      m_waited = 0;
      if (!dma_req) begin
        m_dma = 0; m_beats = 0;
      end else begin
        m_beats++;
        if (m_beats == int'(BURST_MAX)) begin m_dma = 0; m_beats = 0; end
      end
    end else if (!dma_req) begin
      m_waited = 0;
    end else if (!core_req || m_waited == int'(STARVE_LIMIT) - 1) begin
      m_dma = 1; m_waited = 0;
    end else begin
      m_waited++;
    end
  endtask

  task automatic tick();
    @(negedge clock);
    step_model();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_gnt(input int bound, output int n);
    n = 0;
    do begin tick(); n++; end while (!last_gnt && n < bound);
    chk("gnt_timeout", {31'b0, last_gnt}, 32'd1);
  endtask

  task automatic set_core(input logic req, input logic we, input int addr, input logic [31:0] d);
    core_req = req; core_we = we; core_addr = AW'(addr); core_wdata = d;
  endtask

  task automatic set_dma(input logic req, input logic we, input int addr, input logic [31:0] d);
    dma_req = req; dma_we = we; dma_addr = AW'(addr); dma_wdata = d;
  endtask

  initial begin
    int n, total;
    for (int i = 0; i < 1024; i++) exp_mem[i] = '0;
    model_reset();
    last_gnt = 0; last_stall = 0;
    nreset = 1'b0;
    set_core(0, 0, 0, 0);
    set_dma(0, 0, 0, 0);
    repeat (2) @(posedge clock);
    #1;
    chk("rst_rvalid", {31'b0, dma_rvalid}, 32'd0);
    chk("rst_rdata", dma_rdata, 32'd0);
    chk("rst_ram_we", {31'b0, ram_we}, 32'd0);
    chk("rst_gnt", {31'b0, dma_gnt}, 32'd0);
    chk("rst_stall", {31'b0, core_stall}, 32'd0);
    nreset = 1'b1;

    // 1: core store then load
    set_core(1, 1, 0, 100);
    tick();
    set_core(1, 0, 0, 0);
    chk("t1_mem0", mem[0], 32'd100);
    chk("t1_load", core_rdata, 32'd100);
    tick();
    set_core(0, 0, 0, 0);
    tick();

    // 2: 12-beat DMA write burst, split 8 + 4
    total = 0;
    for (int k = 0; k < 12; k++) begin
      set_dma(1, 1, 'h40 + k, 32'(k + 1));
      wait_gnt(20, n);
      total += n;
    end
    set_dma(0, 0, 0, 0);
    tick();
    chk("t2_cycles", 32'(total), 32'd14);
    for (int k = 0; k < 12; k++) chk("t2_mem", mem['h40 + k], 32'(k + 1));

    // 3: DMA read returns data one cycle after grant
    set_core(1, 1, 'h40, 32'hA5A5A5A5);
    tick();
    set_core(0, 0, 0, 0);
    set_dma(1, 0, 'h40, 0);
    wait_gnt(10, n);
    set_dma(0, 0, 0, 0);
    chk("t3_rvalid", {31'b0, dma_rvalid}, 32'd1);
    chk("t3_rdata", dma_rdata, 32'hA5A5A5A5);
    tick();

    // 4: starvation pre-empts a continuously requesting core
    set_core(1, 0, 3, 0);
    set_dma(1, 1, 'h80, 32'h1234);
    wait_gnt(40, n);
    chk("t4_starve_wait", 32'(n), 32'(STARVE_LIMIT + 1));
    set_dma(1, 1, 'h81, 32'h5678);
    wait_gnt(5, n);
    chk("t4_second_beat", 32'(n), 32'd1);
    set_dma(0, 0, 0, 0);
    tick();
    chk("t4_mem", mem['h81], 32'h5678);
    set_core(0, 0, 0, 0);
    tick();

    // 5: same-cycle writes to addr 5; core first, DMA later
    set_core(1, 1, 5, 7);
    set_dma(1, 1, 5, 9);
    tick();
    chk("t5_core_first", mem[5], 32'd7);
    set_core(0, 0, 0, 0);
    wait_gnt(5, n);
    set_dma(0, 0, 0, 0);
    tick();
    chk("t5_final", mem[5], 32'd9);

    // 6: async reset during beat 3 of a burst
    for (int k = 0; k < 2; k++) begin
      set_dma(1, 1, 'h100 + k, 32'(k + 'h200));
      wait_gnt(10, n);
    end
    set_dma(1, 1, 'h102, 32'h202);
    #1 nreset = 1'b0;
    #1;
    chk("t6_gnt", {31'b0, dma_gnt}, 32'd0);
    chk("t6_rvalid", {31'b0, dma_rvalid}, 32'd0);
    chk("t6_ram_we", {31'b0, ram_we}, 32'd0);
    model_reset();
    @(posedge clock);
    #1;
    chk("t6_no_write", mem['h102], 32'd0);
    nreset = 1'b1;
    set_dma(0, 0, 0, 0);
    set_core(1, 1, 9, 55);
    tick();
    chk("t6_core_store", mem[9], 32'd55);
    set_core(0, 0, 0, 0);
    tick();

    // Randomized traffic obeying the hold-until-accepted protocols
    last_gnt = 0; last_stall = 0;
    for (int i = 0; i < 400; i++) begin
      if (!(dma_req && !last_gnt)) begin
        dma_req   = ($urandom_range(0, 2) == 0);
        dma_we    = 1'($urandom_range(0, 1));
        dma_addr  = AW'($urandom_range(0, 31));
        dma_wdata = $urandom;
      end
      if (!last_stall) begin
        core_req   = 1'($urandom_range(0, 1));
        core_we    = 1'($urandom_range(0, 1));
        core_addr  = AW'($urandom_range(0, 31));
        core_wdata = $urandom;
      end
      tick();
    end
    for (int i = 0; i < 32; i++) chk("rand_mem", mem[i], exp_mem[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
